// File: rtl/sc_max7219_rx.sv
// ---------------------------------------------------------------------------
// sc_max7219_rx
// Receiving end of the MAX7219 3-wire serial link (din / ncs / sclk) as
// driven by matrix_ctrl. The link is oversampled on the system clock, each
// 16-bit word is deframed and decoded into a shadow copy of the MAX7219
// register file. This lets the LED-matrix path be monitored on chip or
// scoreboarded in a bench.
//
// Ports
//   SC_MAX7219RX_CLOCK_50          system clock, all logic on rising edge
//   SC_MAX7219RX_RESET_InLow       asynchronous reset, active low
//   SC_MAX7219RX_din_In            serial data
//   SC_MAX7219RX_ncs_In            load / chip select, active low
//   SC_MAX7219RX_sclk_In           serial clock
//   SC_MAX7219RX_digitSel_InBUS    digit register to read (0..7)
//   SC_MAX7219RX_digit_OutBUS      selected digit register, one-cycle read latency
//   SC_MAX7219RX_frameAddr_OutBUS  address field of the last committed frame
//   SC_MAX7219RX_frameData_OutBUS  data field of the last committed frame
//   SC_MAX7219RX_frameValid_Out    one-cycle pulse: a full frame was committed
//   SC_MAX7219RX_frameError_Out    one-cycle pulse: ncs rose before 16 bits arrived
//   SC_MAX7219RX_decode_OutBUS     decode-mode register
//   SC_MAX7219RX_intensity_OutBUS  intensity register
//   SC_MAX7219RX_scanLimit_OutBUS  scan-limit register
//   SC_MAX7219RX_displayOn_Out     shutdown register bit 0 (0 = shutdown)
//   SC_MAX7219RX_testMode_Out      display-test register bit 0
// ---------------------------------------------------------------------------
module sc_max7219_rx #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int FRAME_BITS    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     SC_MAX7219RX_CLOCK_50,
    input  logic                     SC_MAX7219RX_RESET_InLow,
    input  logic                     SC_MAX7219RX_din_In,
    input  logic                     SC_MAX7219RX_ncs_In,
    input  logic                     SC_MAX7219RX_sclk_In,
    input  logic [2:0]               SC_MAX7219RX_digitSel_InBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219RX_digit_OutBUS,
    output logic [3:0]               SC_MAX7219RX_frameAddr_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219RX_frameData_OutBUS,
    output logic                     SC_MAX7219RX_frameValid_Out,
    output logic                     SC_MAX7219RX_frameError_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219RX_decode_OutBUS,
    output logic [3:0]               SC_MAX7219RX_intensity_OutBUS,
    output logic [2:0]               SC_MAX7219RX_scanLimit_OutBUS,
    output logic                     SC_MAX7219RX_displayOn_Out,
    output logic                     SC_MAX7219RX_testMode_Out
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    // The top nibble of every frame is ignored, so only the address and data
    // fields of the most recent bits need to be kept; this still gives
    // "last 16 bits win" for over-long bursts.
    localparam int SR_W  = DATAWIDTH_BUS + 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } rxState_t;

    // Bit counter that stops at a full frame.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(FRAME_BITS)) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    rxState_t                 state, nextState;
    logic [SYNC_STAGES-1:0]   dinSync, ncsSync, sclkSync;
    logic                     dinS, ncsS, sclkS;
    logic                     sclkPrev;
    logic                     sclkRise;
    logic [SR_W-1:0]          shiftReg;
    logic [CNT_W-1:0]         bitCnt;
    logic [DATAWIDTH_BUS-1:0] digitReg [8];
    logic [3:0]               frmAddr;
    logic [DATAWIDTH_BUS-1:0] frmData;
    logic [2:0]               digitIdx;

    // ---- stage: input synchronizers (ncs idles high so no false frame start)
    always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
        if (!SC_MAX7219RX_RESET_InLow) begin
            dinSync  <= '0;
            ncsSync  <= '1;
            sclkSync <= '0;
            sclkPrev <= 1'b0;
        end else begin
            dinSync  <= {dinSync[SYNC_STAGES-2:0],  SC_MAX7219RX_din_In};
            ncsSync  <= {ncsSync[SYNC_STAGES-2:0],  SC_MAX7219RX_ncs_In};
            sclkSync <= {sclkSync[SYNC_STAGES-2:0], SC_MAX7219RX_sclk_In};
            sclkPrev <= sclkS;
        end
    end

    assign dinS     = dinSync[SYNC_STAGES-1];
    assign ncsS     = ncsSync[SYNC_STAGES-1];
    assign sclkS    = sclkSync[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev;

    assign frmAddr  = shiftReg[SR_W-1:DATAWIDTH_BUS];
    assign frmData  = shiftReg[DATAWIDTH_BUS-1:0];
    assign digitIdx = 3'(frmAddr - 4'd1);

    // ---- stage: frame FSM
    always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
        if (!SC_MAX7219RX_RESET_InLow) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Level-sensitive on ncs: a falling ncs that arrives while in COMMIT is
    // picked up by IDLE on the following cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!ncsS) nextState = SHIFT;
            SHIFT:   if (ncsS)  nextState = COMMIT;
            COMMIT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ---- stage: shift, commit and register file
    always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
        if (!SC_MAX7219RX_RESET_InLow) begin
            shiftReg                      <= '0;
            bitCnt                        <= '0;
            for (int i = 0; i < 8; i++) begin
                digitReg[i] <= '0;
            end
            SC_MAX7219RX_digit_OutBUS     <= '0;
            SC_MAX7219RX_frameAddr_OutBUS <= '0;
            SC_MAX7219RX_frameData_OutBUS <= '0;
            SC_MAX7219RX_frameValid_Out   <= 1'b0;
            SC_MAX7219RX_frameError_Out   <= 1'b0;
            SC_MAX7219RX_decode_OutBUS    <= '0;
            SC_MAX7219RX_intensity_OutBUS <= '0;
            SC_MAX7219RX_scanLimit_OutBUS <= '0;
            SC_MAX7219RX_displayOn_Out    <= 1'b0;
            SC_MAX7219RX_testMode_Out     <= 1'b0;
        end else begin
            SC_MAX7219RX_frameValid_Out <= 1'b0;
            SC_MAX7219RX_frameError_Out <= 1'b0;
            // Registered read: a write to the same digit in this cycle is
            // seen on the next read.
            SC_MAX7219RX_digit_OutBUS   <= digitReg[SC_MAX7219RX_digitSel_InBUS];

            case (state)
                IDLE: begin
                    if (!ncsS) begin
                        shiftReg <= '0;
                        bitCnt   <= '0;
                    end
                end
                SHIFT: begin
                    // ncs rising wins over a coincident sclk edge.
                    if (!ncsS && sclkRise) begin
                        shiftReg <= {shiftReg[SR_W-2:0], dinS};
                        bitCnt   <= satInc(bitCnt);
                    end
                end
                COMMIT: begin
                    if (bitCnt == CNT_W'(FRAME_BITS)) begin
                        SC_MAX7219RX_frameValid_Out   <= 1'b1;
                        SC_MAX7219RX_frameAddr_OutBUS <= frmAddr;
                        SC_MAX7219RX_frameData_OutBUS <= frmData;
                        case (frmAddr)
                            4'h1, 4'h2, 4'h3, 4'h4,
                            4'h5, 4'h6, 4'h7, 4'h8: digitReg[digitIdx] <= frmData;
                            4'h9: SC_MAX7219RX_decode_OutBUS    <= frmData;
                            4'hA: SC_MAX7219RX_intensity_OutBUS <= frmData[3:0];
                            4'hB: SC_MAX7219RX_scanLimit_OutBUS <= frmData[2:0];
                            4'hC: SC_MAX7219RX_displayOn_Out    <= frmData[0];
                            4'hF: SC_MAX7219RX_testMode_Out     <= frmData[0];
                            default: ;  // no-op (0) and unused D/E
                        endcase
                    end else begin
                        SC_MAX7219RX_frameError_Out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_max7219_rx.sv
module tb_sc_max7219_rx;

    logic       clk = 1'b0;
    logic       rstN;
    logic       din, ncs, sclk;
    logic [2:0] sel;
    logic [7:0] digitOut, frameData, decodeOut;
    logic [3:0] frameAddr, intensity;
    logic [2:0] scanLimit;
    logic       frameValid, frameError, displayOn, testMode;

    int checks   = 0;
    int failures = 0;
    int validCnt = 0;
    int errCnt   = 0;

    // Shadow of the MAX7219 register file, updated from whole frames.
    logic [7:0] mDigit [8];
    logic [7:0] mDecode, mData;
    logic [3:0] mInt, mAddr;
    logic [2:0] mScan;
    logic       mOn, mTest;

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic        expV;
        logic        expE;
        logic [3:0]  addr;
        logic [7:0]  data;
    } vec_t;
    vec_t vecs [13];

    sc_max7219_rx dut (
        .SC_MAX7219RX_CLOCK_50        (clk),
        .SC_MAX7219RX_RESET_InLow     (rstN),
        .SC_MAX7219RX_din_In          (din),
        .SC_MAX7219RX_ncs_In          (ncs),
        .SC_MAX7219RX_sclk_In         (sclk),
        .SC_MAX7219RX_digitSel_InBUS  (sel),
        .SC_MAX7219RX_digit_OutBUS    (digitOut),
        .SC_MAX7219RX_frameAddr_OutBUS(frameAddr),
        .SC_MAX7219RX_frameData_OutBUS(frameData),
        .SC_MAX7219RX_frameValid_Out  (frameValid),
        .SC_MAX7219RX_frameError_Out  (frameError),
        .SC_MAX7219RX_decode_OutBUS   (decodeOut),
        .SC_MAX7219RX_intensity_OutBUS(intensity),
        .SC_MAX7219RX_scanLimit_OutBUS(scanLimit),
        .SC_MAX7219RX_displayOn_Out   (displayOn),
        .SC_MAX7219RX_testMode_Out    (testMode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frameValid === 1'b1) validCnt <= validCnt + 1;
        if (frameError === 1'b1) errCnt   <= errCnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mDigit[i] = 8'h00;
        mDecode = 8'h00; mInt = 4'h0; mScan = 3'h0; mOn = 1'b0; mTest = 1'b0;
        mAddr = 4'h0; mData = 8'h00;
    endtask

    // A frame is the last 16 bits shifted; anything shorter is an error.
    task automatic modelFrame(input logic [31:0] bits, input int n,
                              output logic expV, output logic expE);
        logic [15:0] word;
        logic [3:0]  a;
        logic [7:0]  d;
        expV = 1'b0;
        expE = 1'b0;
        if (n < 16) begin
            expE = 1'b1;
        end else begin
            expV = 1'b1;
            word = bits[15:0];
            a = word[11:8];
            d = word[7:0];
            mAddr = a;
            mData = d;
            if (a >= 4'd1 && a <= 4'd8) mDigit[int'(a) - 1] = d;
            else if (a == 4'h9) mDecode = d;
            else if (a == 4'hA) mInt = d[3:0];
            else if (a == 4'hB) mScan = d[2:0];
            else if (a == 4'hC) mOn = d[0];
            else if (a == 4'hF) mTest = d[0];
        end
    endtask

    task automatic shiftBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i];
            waitClk(4);
            sclk = 1'b1;
            waitClk(4);
            sclk = 1'b0;
        end
    endtask

    // Returns the number of clocks from raw ncs rise to the first pulse.
    task automatic sendFrame(input logic [31:0] bits, input int n, output int lat);
        ncs = 1'b0;
        waitClk(4);
        shiftBits(bits, n);
        waitClk(4);
        ncs = 1'b1;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat < 0 && (frameValid === 1'b1 || frameError === 1'b1)) lat = i;
        end
    endtask

    task automatic checkRegs(input string tag);
        chk({tag, " decode"},    decodeOut, mDecode);
        chk({tag, " intensity"}, intensity, mInt);
        chk({tag, " scanLimit"}, scanLimit, mScan);
        chk({tag, " displayOn"}, displayOn, mOn);
        chk({tag, " testMode"},  testMode,  mTest);
        for (int d = 0; d < 8; d++) begin
            sel = 3'(d);
            waitClk(2);
            chk($sformatf("%s digit%0d", tag, d), digitOut, mDigit[d]);
        end
    endtask

    task automatic runFrame(input logic [31:0] bits, input int n, input string tag);
        int   v0, e0, lat;
        logic expV, expE;
        v0 = validCnt;
        e0 = errCnt;
        modelFrame(bits, n, expV, expE);
        sendFrame(bits, n, lat);
        chk({tag, " validPulses"}, validCnt - v0, expV);
        chk({tag, " errorPulses"}, errCnt - e0, expE);
        chk({tag, " latency"}, lat, 4);
        chk({tag, " frameAddr"}, frameAddr, mAddr);
        chk({tag, " frameData"}, frameData, mData);
        checkRegs(tag);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, " digit"},     digitOut,   0);
        chk({tag, " frameAddr"}, frameAddr,  0);
        chk({tag, " frameData"}, frameData,  0);
        chk({tag, " valid"},     frameValid, 0);
        chk({tag, " error"},     frameError, 0);
        chk({tag, " decode"},    decodeOut,  0);
        chk({tag, " intensity"}, intensity,  0);
        chk({tag, " scanLimit"}, scanLimit,  0);
        chk({tag, " displayOn"}, displayOn,  0);
        chk({tag, " testMode"},  testMode,   0);
    endtask

    initial begin
        int v0, e0, n, r;
        logic [31:0] bits;
        logic dV, dE;

        vecs[0]  = '{32'h0000_0155, 16, 1'b1, 1'b0, 4'h1, 8'h55};
        vecs[1]  = '{32'h0000_0A0F, 16, 1'b1, 1'b0, 4'hA, 8'h0F};
        vecs[2]  = '{32'h0000_0B07, 16, 1'b1, 1'b0, 4'hB, 8'h07};
        vecs[3]  = '{32'h0000_0C01, 16, 1'b1, 1'b0, 4'hC, 8'h01};
        vecs[4]  = '{32'h0000_0F01, 16, 1'b1, 1'b0, 4'hF, 8'h01};
        vecs[5]  = '{32'h0000_0ABC, 12, 1'b0, 1'b1, 4'h0, 8'h00};
        vecs[6]  = '{32'h000F_0833, 20, 1'b1, 1'b0, 4'h8, 8'h33};
        vecs[7]  = '{32'h0000_0D12, 16, 1'b1, 1'b0, 4'hD, 8'h12};
        vecs[8]  = '{32'h0000_0000, 16, 1'b1, 1'b0, 4'h0, 8'h00};
        vecs[9]  = '{32'h0000_09A5, 16, 1'b1, 1'b0, 4'h9, 8'hA5};
        vecs[10] = '{32'h0000_F3AA, 16, 1'b1, 1'b0, 4'h3, 8'hAA};
        vecs[11] = '{32'h0000_0001,  1, 1'b0, 1'b1, 4'h0, 8'h00};
        vecs[12] = '{32'h0000_7FFF, 15, 1'b0, 1'b1, 4'h0, 8'h00};

        rstN = 1'b0; din = 1'b0; ncs = 1'b1; sclk = 1'b0; sel = 3'd0;
        modelReset();
        waitClk(3);
        checkAllZero("reset");
        rstN = 1'b1;
        waitClk(5);

        for (int i = 0; i < 13; i++) begin
            v0 = validCnt;
            e0 = errCnt;
            runFrame(vecs[i].bits, vecs[i].n, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tableValid", i), validCnt - v0, vecs[i].expV);
            chk($sformatf("vec%0d tableError", i), errCnt - e0, vecs[i].expE);
            if (vecs[i].expV) begin
                chk($sformatf("vec%0d tableAddr", i), frameAddr, vecs[i].addr);
                chk($sformatf("vec%0d tableData", i), frameData, vecs[i].data);
            end
        end

        chk("T3 intensity", intensity, 4'hF);
        chk("T3 scanLimit", scanLimit, 3'h7);
        chk("T3 displayOn", displayOn, 1'b1);
        chk("T3 testMode",  testMode,  1'b1);
        sel = 3'd0; waitClk(2); chk("T2 digit0", digitOut, 8'h55);
        sel = 3'd7; waitClk(2); chk("T5 digit7", digitOut, 8'h33);
        sel = 3'd2; waitClk(2); chk("hiNibble digit2", digitOut, 8'hAA);

        // T1: reset in the middle of a frame after 9 bits
        v0 = validCnt;
        e0 = errCnt;
        ncs = 1'b0;
        waitClk(4);
        shiftBits(32'h0000_01FF, 9);
        rstN = 1'b0;
        waitClk(2);
        checkAllZero("T1 inReset");
        ncs = 1'b1; sclk = 1'b0; din = 1'b0;
        waitClk(3);
        rstN = 1'b1;
        waitClk(12);
        chk("T1 validPulses", validCnt - v0, 0);
        chk("T1 errorPulses", errCnt - e0, 0);
        modelReset();
        checkRegs("T1 idle");

        // T6: back-to-back frames with a 3-clock ncs gap
        v0 = validCnt;
        e0 = errCnt;
        ncs = 1'b0;
        waitClk(4);
        shiftBits(32'h0000_0201, 16);
        waitClk(4);
        ncs = 1'b1;
        waitClk(3);
        ncs = 1'b0;
        waitClk(4);
        shiftBits(32'h0000_0202, 16);
        waitClk(4);
        ncs = 1'b1;
        waitClk(12);
        modelFrame(32'h0000_0201, 16, dV, dE);
        modelFrame(32'h0000_0202, 16, dV, dE);
        chk("T6 validPulses", validCnt - v0, 2);
        chk("T6 errorPulses", errCnt - e0, 0);
        sel = 3'd1; waitClk(2); chk("T6 digit1", digitOut, 8'h02);
        checkRegs("T6");

        // Randomized frames of varying length against the shadow model
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      n = int'($urandom_range(1, 15));
            else if (r == 1) n = int'($urandom_range(17, 20));
            else             n = 16;
            bits = $urandom;
            runFrame(bits, n, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
